// File: rtl/servo_pkg.sv
// Shared servo definitions: motion states and joint defaults.
// Also consumed by the PWM stage for period and range.
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MOVING,
    HOLD
  } servo_state_e;

  localparam int DEF_STEP_CYCLES = 1_000_000;
  localparam int DEF_MAX_POS     = 85;
  localparam int DEF_HOME_POS    = 25;

  function automatic logic [15:0] clamp_pos(
    input logic [15:0] pos,
    input logic [15:0] max_pos
  );
    return (pos > max_pos) ? max_pos : pos;
  endfunction

endpackage

// File: rtl/step_tick.sv
// Free-running tick generator: one-cycle pulse every CYCLES clocks.
// Shared by the arm joints; commands never restart it.
module step_tick #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/servo_ramp.sv
// Motion shaper: slews data toward an accepted target one bounded
// step per tick, then holds position before releasing the PWM enable.
module servo_ramp
  import servo_pkg::*;
#(
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int STEP        = 1,
  parameter int MAX_POS     = DEF_MAX_POS,
  parameter int HOME_POS    = DEF_HOME_POS,
  parameter int HOLD_TICKS  = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_pos,
  output logic        cmd_ready,
  output logic        en,
  output logic [15:0] data,
  output logic        busy,
  output logic        at_target
);

  localparam logic [15:0] MAX_W  = 16'(MAX_POS);
  localparam logic [15:0] HOME_W = 16'(HOME_POS);
  localparam logic [16:0] STEP_W = 17'(STEP);
  localparam logic [15:0] HOLD_W = 16'(HOLD_TICKS);
  localparam bit          HOLD_FOREVER = (HOLD_TICKS == 0);

  servo_state_e state_q, state_d;
  logic [15:0]  data_q, data_d;
  logic [15:0]  target_q, target_d;
  logic [15:0]  hold_q, hold_d;
  logic         en_q, ready_q;

  logic        tick;
  logic        accept;
  logic [15:0] clamped;
  logic [16:0] diff;
  logic [16:0] mag;
  logic [16:0] step;
  logic [15:0] stepped;
  logic [15:0] hold_inc;

  step_tick #(
    .CYCLES(STEP_CYCLES)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign accept  = cmd_valid & ready_q;
  assign clamped = clamp_pos(cmd_pos, MAX_W);

  // 17-bit signed difference keeps the step direction exact at the rails
  assign diff = {1'b0, target_q} - {1'b0, data_q};
  assign mag  = diff[16] ? (~diff + 17'd1) : diff;
  assign step = (mag > STEP_W) ? STEP_W : mag;

  always_comb begin
    stepped = data_q;
    unique case (1'b1)
      diff[16]:  stepped = data_q - step[15:0];
      !diff[16]: stepped = data_q + step[15:0];
    endcase
  end

  assign hold_inc = hold_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    target_d = target_q;
    hold_d   = hold_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = clamped;
          hold_d   = '0;
          state_d  = (clamped == data_q) ? HOLD : MOVING;
        end
      end
      MOVING: begin
        if (tick) begin
          data_d = stepped;
          if (stepped == target_q) begin
            state_d = HOLD;
            hold_d  = '0;
          end
        end
      end
      HOLD: begin
        // an accept on a tick edge wins; that tick is not counted
        if (accept) begin
          target_d = clamped;
          hold_d   = '0;
          if (clamped != data_q) begin
            state_d = MOVING;
          end
        end else if (tick && !HOLD_FOREVER) begin
          hold_d = hold_inc;
          if (hold_inc == HOLD_W) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= HOME_W;
      target_q <= HOME_W;
      hold_q   <= '0;
      en_q     <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      target_q <= target_d;
      hold_q   <= hold_d;
      en_q     <= (state_d != IDLE);
      ready_q  <= (state_d != MOVING);
    end
  end

  assign cmd_ready = ready_q;
  assign en        = en_q;
  assign data      = data_q;
  assign busy      = (state_q == MOVING);
  assign at_target = (data_q == target_q);

endmodule

// File: tb/tb_servo_ramp.sv
// Scoreboard bench for servo_ramp: a reference model predicts every
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_servo_ramp;

  localparam int SC = 4;
  localparam int ST = 5;
  localparam int MP = 85;
  localparam int HP = 25;
  localparam int HT = 3;
  localparam int BOUND = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_pos = '0;
  logic        cmd_ready;
  logic        en;
  logic [15:0] data;
  logic        busy;
  logic        at_target;

  always #5 clk = ~clk;

  servo_ramp #(
    .STEP_CYCLES(SC),
    .STEP       (ST),
    .MAX_POS    (MP),
    .HOME_POS   (HP),
    .HOLD_TICKS (HT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_pos  (cmd_pos),
    .cmd_ready(cmd_ready),
    .en       (en),
    .data     (data),
    .busy     (busy),
    .at_target(at_target)
  );

  typedef struct {
    bit en;
    int data;
    bit ready;
    bit busy;
    bit at;
  } exp_t;

  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;

  // reference model: position, target, and what the joint is doing
  int m_pos = HP;
  int m_tgt = HP;
  int m_cyc = 0;
  int m_hold = 0;
  int m_acc = 0;
  bit m_move = 0;
  bit m_holding = 0;

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit tick;
    bit acc;
    int cl;
    int d;
    tick = (m_cyc % SC) == (SC - 1);
    m_cyc++;
    acc = cmd_valid && !m_move;
    cl = (int'(cmd_pos) > MP) ? MP : int'(cmd_pos);
    if (acc) m_acc++;
    if (m_move) begin
      if (tick) begin
        d = m_tgt - m_pos;
        if (d > ST) d = ST;
        if (d < -ST) d = -ST;
        m_pos += d;
        if (m_pos == m_tgt) begin
          m_move = 0;
          m_holding = 1;
          m_hold = 0;
        end
      end
    end else if (acc) begin
      m_tgt = cl;
      m_hold = 0;
      m_holding = (cl == m_pos);
      m_move = (cl != m_pos);
    end else if (m_holding && tick) begin
      m_hold++;
      if (HT != 0 && m_hold == HT) m_holding = 0;
    end
    q.push_back('{en: m_move || m_holding, data: m_pos,
                  ready: !m_move, busy: m_move,
                  at: m_pos == m_tgt});
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos = HP;
      m_tgt = HP;
      m_cyc = 0;
      m_hold = 0;
      m_move = 0;
      m_holding = 0;
      q.delete();
    end else begin
      model_edge();
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      check("en", int'(en), int'(e.en));
      check("data", int'(data), e.data);
      check("cmd_ready", int'(cmd_ready), int'(e.ready));
      check("busy", int'(busy), int'(e.busy));
      check("at_target", int'(at_target), int'(e.at));
    end
  end

  task automatic send(int pos);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_pos = 16'(pos);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while ((m_move || m_holding) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, int'(n < BOUND), 1);
  endtask

  task automatic async_reset(string name);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check({name, "_en"}, int'(en), 0);
    check({name, "_data"}, int'(data), HP);
    check({name, "_ready"}, int'(cmd_ready), 1);
    check({name, "_at"}, int'(at_target), 1);
    check({name, "_busy"}, int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int r;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    async_reset("reset");

    send(40);
    wait_idle("ramp");
    send(200);
    wait_idle("clamp");
    send(82);

    // retarget after the 2nd hold tick, on the edge of the 3rd tick
    n = 0;
    while (!(m_holding && m_hold == 2 && (m_cyc % SC) == SC - 1)
           && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("hold2_timeout", int'(n < BOUND), 1);
    cmd_valid = 1'b1;
    cmd_pos = 16'd60;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("retarget_moving", int'(m_move), 1);

    // valid held through MOVING is only taken once HOLD is reached
    r = m_acc;
    cmd_valid = 1'b1;
    cmd_pos = 16'd30;
    n = 0;
    while (m_acc == r && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    check("held_valid_timeout", int'(n < BOUND), 1);
    wait_idle("held");

    send(m_pos);
    wait_idle("equal");

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b1;
        r = int'($urandom_range(0, 9));
        cmd_pos = (r == 0) ? 16'(m_pos)
                           : 16'($urandom_range(0, 130));
      end else begin
        cmd_valid = 1'b0;
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle("random");

    send(80);
    repeat (9) @(negedge clk);
    async_reset("midmove");
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
